// File: rtl/image_window_fetch_ctrl.sv
// Walks a rectangular image region window by window: drives the ROM window address, captures the
// returned words and streams them one word per valid/ready beat with row/region end markers.
module image_window_fetch_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ADDR_W  = 19,
    parameter int WORDS   = 10,
    parameter int ROM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [9:0]            win_per_row,
    input  logic [8:0]            rows,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [16*WORDS-1:0]   rom_data,
    output logic [15:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_eol,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ROM_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM, DONE} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   row_base;
    logic [9:0]          wpr_q;
    logic [8:0]          rows_q;
    logic [9:0]          col;
    logic [8:0]          row;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    lat_cnt;
    logic [15:0]         win_buf [WORDS];

    logic [31:0]         cfg_end;
    logic                cfg_ok;
    logic                beat;
    logic                last_word;
    logic                last_col;
    logic                last_row;

    // Region must end inside the ROM; checked in 32 bits so the sum itself cannot wrap.
    assign cfg_end = 32'(base_addr) + (32'(rows) - 32'd1) * 32'(IMG_W)
                   + 32'(win_per_row) * 32'(2 * WORDS);
    assign cfg_ok  = (win_per_row != 10'd0) && (rows != 9'd0) && (cfg_end <= 32'(IMG_W * IMG_H));

    assign out_valid = (state == STREAM);
    assign out_data  = out_valid ? win_buf[idx] : 16'd0;
    assign beat      = out_valid && out_ready;
    assign last_word = (idx == IDX_LAST);
    assign last_col  = (col == wpr_q - 10'd1);
    assign last_row  = (row == rows_q - 9'd1);
    assign out_eol   = out_valid && last_word && last_col;
    assign out_last  = out_eol && last_row;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && cfg_ok) state_nx = WAIT;
            WAIT:    if (lat_cnt == LAT_LAST) state_nx = STREAM;
            STREAM:  if (beat && last_word) state_nx = (last_col && last_row) ? DONE : WAIT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            row_base <= '0;
            wpr_q    <= '0;
            rows_q   <= '0;
            col      <= '0;
            row      <= '0;
            idx      <= '0;
            lat_cnt  <= '0;
            err      <= 1'b0;
            for (int k = 0; k < WORDS; k++) win_buf[k] <= 16'd0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            wpr_q    <= win_per_row;
                            rows_q   <= rows;
                            rom_addr <= base_addr;
                            row_base <= base_addr;
                            col      <= '0;
                            row      <= '0;
                            lat_cnt  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!abort) begin
                        if (lat_cnt == LAT_LAST) begin
                            for (int k = 0; k < WORDS; k++) win_buf[k] <= rom_data[16*k +: 16];
                            idx <= '0;
                        end else begin
                            lat_cnt <= lat_cnt + CNT_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (beat && !abort) begin
                        if (last_word) begin
                            idx     <= '0;
                            lat_cnt <= '0;
                            // Next window: step along the row, or wrap to the next row's base.
                            if (!(last_col && last_row)) begin
                                if (last_col) begin
                                    col      <= '0;
                                    row      <= row + 9'd1;
                                    row_base <= row_base + ADDR_W'(IMG_W);
                                    rom_addr <= row_base + ADDR_W'(IMG_W);
                                end else begin
                                    col      <= col + 10'd1;
                                    rom_addr <= rom_addr + ADDR_W'(2 * WORDS);
                                end
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_window_fetch_ctrl.sv
// Directed bench for image_window_fetch_ctrl: config-acceptance table plus fetch sequences
// (plain, backpressured, multi-window, reset mid-fetch, abort mid-fetch).
module tb_image_window_fetch_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [18:0]  base_addr;
    logic [9:0]   win_per_row;
    logic [8:0]   rows;
    logic [18:0]  rom_addr;
    logic [159:0] rom_data;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_eol;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;

    int checks   = 0;
    int failures = 0;

    image_window_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .win_per_row(win_per_row), .rows(rows),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_eol(out_eol), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: byte[i] = i & 0xFF, one-cycle latency seen as combinational over rom_addr.
    always_comb begin
        rom_data = '0;
        for (int k = 0; k < 10; k++) begin
            rom_data[16*k+8 +: 8] = 8'(32'(rom_addr) + 32'(2*k));
            rom_data[16*k   +: 8] = 8'(32'(rom_addr) + 32'(2*k) + 32'd1);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] win_addr(input int b, input int w, input int n);
        int wi;
        wi = n / 10;
        return 32'(b + (wi / w) * 640 + (wi % w) * 20);
    endfunction

    function automatic logic [15:0] exp_word(input logic [31:0] a, input int k);
        logic [7:0] hi, lo;
        hi = 8'(a + 32'(2*k));
        lo = 8'(a + 32'(2*k) + 32'd1);
        return {hi, lo};
    endfunction

    // Runs one fetch, checking every beat against the model. Negative triggers are disabled.
    task automatic fetch(input int b, input int w, input int r, input int rdy_mode,
                         input int abort_after, input int start_at, input int rst_after,
                         input string tag);
        int total, n, cyc, bad, k, wi;
        bit fin, hold, sx;
        logic [15:0] hd;
        logic [31:0] a;
        total = 10 * w * r;
        n = 0; cyc = 0; fin = 0; hold = 0; sx = 0; hd = '0;
        @(negedge clk);
        base_addr = 19'(b); win_per_row = 10'(w); rows = 9'(r); start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        while (!fin && cyc < 3000) begin
            if (hold) begin
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_data"}, out_data, hd);
            end
            if (done) begin
                check({tag, "_done_beats"}, n, total);
                check({tag, "_done_busy"}, busy, 1);
                @(negedge clk);
                check({tag, "_idle_busy"}, busy, 0);
                check({tag, "_done_pulse"}, done, 0);
                fin = 1;
            end else if (rst_after >= 0 && n == rst_after) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_valid"}, out_valid, 0);
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_addr"}, rom_addr, 0);
                @(negedge clk);
                rst_n = 1'b1;
                bad = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (done || busy || out_valid) bad++;
                end
                check({tag, "_rst_quiet"}, bad, 0);
                fin = 1;
            end else if (abort_after >= 0 && n == abort_after) begin
                a = win_addr(b, w, n);
                abort = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                abort = 1'b0; out_ready = 1'b1;
                check({tag, "_abort_busy"}, busy, 0);
                check({tag, "_abort_valid"}, out_valid, 0);
                check({tag, "_abort_done"}, done, 0);
                check({tag, "_abort_addr"}, rom_addr, a);
                bad = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (done || busy || out_valid) bad++;
                end
                check({tag, "_abort_quiet"}, bad, 0);
                fin = 1;
            end else begin
                cyc++;
                out_ready = (rdy_mode == 0) ? 1'b1 : cyc[0];
                if (start_at >= 0 && n == start_at && !sx) begin
                    start = 1'b1; base_addr = 19'd1000; sx = 1;
                end
                if (out_valid && out_ready) begin
                    k  = n % 10;
                    wi = n / 10;
                    a  = win_addr(b, w, n);
                    if (k == 0) check({tag, "_rom_addr"}, rom_addr, a);
                    check({tag, "_data"}, out_data, exp_word(a, k));
                    check({tag, "_eol"}, out_eol, (k == 9 && (wi % w) == w - 1) ? 1 : 0);
                    check({tag, "_last"}, out_last, (k == 9 && wi == w * r - 1) ? 1 : 0);
                    n++;
                end
                hold = out_valid && !out_ready;
                hd   = out_data;
                @(negedge clk);
                start = 1'b0;
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: beats %0d of %0d, no completion", tag, n, total);
        end
    endtask

    typedef struct {
        int base;
        int wpr;
        int nrows;
        bit exp_err;
    } cfg_vec_t;

    cfg_vec_t cfg_tbl [7];

    initial begin
        cfg_tbl[0] = '{0,      0,  1,   1'b1};
        cfg_tbl[1] = '{0,      1,  0,   1'b1};
        cfg_tbl[2] = '{307190, 1,  1,   1'b1};
        cfg_tbl[3] = '{307180, 1,  1,   1'b0};
        cfg_tbl[4] = '{0,      32, 480, 1'b0};
        cfg_tbl[5] = '{0,      33, 480, 1'b1};
        cfg_tbl[6] = '{1,      32, 480, 1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; win_per_row = '0; rows = '0;
        #1;
        check("rst_rom_addr", rom_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_eol_last", {out_eol, out_last}, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            base_addr = 19'(cfg_tbl[i].base);
            win_per_row = 10'(cfg_tbl[i].wpr);
            rows = 9'(cfg_tbl[i].nrows);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check($sformatf("cfg%0d_err", i), err, cfg_tbl[i].exp_err);
            check($sformatf("cfg%0d_busy", i), busy, !cfg_tbl[i].exp_err);
            if (!cfg_tbl[i].exp_err) begin
                check($sformatf("cfg%0d_addr", i), rom_addr, cfg_tbl[i].base);
                abort = 1'b1;
            end
            @(negedge clk);
            abort = 1'b0;
            check($sformatf("cfg%0d_err_clr", i), err, 0);
            check($sformatf("cfg%0d_idle", i), busy, 0);
        end

        fetch(0, 1, 1, 0, -1, -1, -1, "t1");
        fetch(0, 1, 1, 1, -1, -1, -1, "t2");
        fetch(0, 2, 2, 0, -1, -1, -1, "t3");
        fetch(0, 1, 1, 0, -1, -1, 5,  "t5rst");
        fetch(0, 1, 1, 0, -1, -1, -1, "t5re");
        fetch(0, 2, 2, 0, 15, 5, -1,  "t6");
        fetch(0, 2, 2, 1, -1, -1, -1, "t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
